// File: rtl/bit_deserializer_if.sv
// Bus between a serial bit source and the bit deserializer.
interface bit_deserializer_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             din;
  logic             din_en;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;
  logic             frame_err;

  // Bit source side
  modport master (
    output din, din_en,
    input  dout, dout_valid, busy, frame_err
  );

  // Deserializer side
  modport slave (
    input  din, din_en,
    output dout, dout_valid, busy, frame_err
  );
endinterface

// File: rtl/bit_deserializer.sv
// Frames a strobed serial bit stream (start=0, WIDTH data bits LSB first, stop=1)
// into parallel words. All outputs are registered.
module bit_deserializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input logic               clk,
  input logic               rst,
  bit_deserializer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StData, StStop} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  // Next-state: everything holds unless a strobed bit arrives; pulses default low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (bus.din_en) begin
      unique case (state_q)
        StIdle: begin
          if (!bus.din) begin
            state_d = StData;
            cnt_d   = '0;
          end
        end
        StData: begin
          // Right shift with new bit at MSB leaves the first data bit in bit 0.
          shift_d = {bus.din, shift_q[WIDTH-1:1]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = StStop;
          end
        end
        StStop: begin
          // A 0 here is a framing error, never a new start bit.
          if (bus.din) begin
            dout_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
    busy_d = (state_d != StIdle);
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.frame_err  = err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// Self-checking bench for bit_deserializer: directed scenarios plus randomized
// frames, every cycle compared against a frame-level reference model.
module tb_bit_deserializer;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst;

  bit_deserializer_if #(.WIDTH(WIDTH)) bus ();

  bit_deserializer #(
    .WIDTH(WIDTH),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pos = -1 when no frame is open, 0..WIDTH-1 = index of the
  // next data bit, WIDTH = awaiting stop bit. Word assembled by bit index.
  int               m_pos = -1;
  logic [WIDTH-1:0] m_word = '0;
  logic [WIDTH-1:0] m_dout = '0;
  bit               m_valid = 1'b0;
  bit               m_err = 1'b0;
  int               n_valid = 0;
  int               n_err = 0;

  function automatic void model_step(input bit r, input bit d, input bit e);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (r) begin
      m_pos  = -1;
      m_word = '0;
      m_dout = '0;
    end else if (e) begin
      if (m_pos < 0) begin
        if (!d) begin
          m_pos  = 0;
          m_word = '0;
        end
      end else if (m_pos < int'(WIDTH)) begin
        m_word[m_pos] = d;
        m_pos++;
      end else begin
        if (d) begin
          m_dout  = m_word;
          m_valid = 1'b1;
          n_valid++;
        end else begin
          m_err = 1'b1;
          n_err++;
        end
        m_pos = -1;
      end
    end
  endfunction

  // One clock: apply inputs, let the edge happen, then compare on the falling edge.
  task automatic cycle(input bit r, input bit d, input bit e);
    rst        = r;
    bus.din    = d;
    bus.din_en = e;
    @(posedge clk);
    model_step(r, d, e);
    @(negedge clk);
    check_eq("dout", 32'(bus.dout), 32'(m_dout));
    check_eq("dout_valid", 32'(bus.dout_valid), 32'(m_valid));
    check_eq("frame_err", 32'(bus.frame_err), 32'(m_err));
    check_eq("busy", 32'(bus.busy), 32'(m_pos >= 0));
  endtask

  // Send one strobed bit; gap-1 filler cycles precede it with din_en=0.
  task automatic send_bit(input bit b, input int gap, input bit rand_fill);
    for (int i = 1; i < gap; i++) begin
      cycle(1'b0, rand_fill ? 1'($urandom) : 1'b1, 1'b0);
    end
    cycle(1'b0, b, 1'b1);
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input bit stop, input int gap,
                            input bit rand_fill);
    send_bit(1'b0, gap, rand_fill);
    for (int i = 0; i < int'(WIDTH); i++) begin
      send_bit(w[i], gap, rand_fill);
    end
    send_bit(stop, gap, rand_fill);
  endtask

  int v0;
  int e0;
  int busy_cycles;

  initial begin
    rst        = 1'b1;
    bus.din    = 1'b0;
    bus.din_en = 1'b1;

    // 1: reset with toggling data and strobe high
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    check_eq("reset_dout", 32'(bus.dout), 32'h0);

    // 2: single frame 0xA5 with continuous strobe; count busy cycles
    v0 = n_valid;
    busy_cycles = 0;
    cycle(1'b0, 1'b0, 1'b1);
    if (bus.busy) busy_cycles++;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, (8'hA5 >> i) & 1'b1, 1'b1);
      if (bus.busy) busy_cycles++;
    end
    cycle(1'b0, 1'b1, 1'b1);
    if (bus.busy) busy_cycles++;
    check_eq("s2_busy_cycles", 32'(busy_cycles), 32'd9);
    check_eq("s2_dout", 32'(bus.dout), 32'hA5);
    check_eq("s2_valid_pulses", 32'(n_valid - v0), 32'd1);
    cycle(1'b0, 1'b1, 1'b1);
    check_eq("s2_valid_drop", 32'(bus.dout_valid), 32'd0);

    // 3: sparse strobe, every third cycle
    cycle(1'b1, 1'b0, 1'b0);
    v0 = n_valid;
    send_frame(8'hA5, 1'b1, 3, 1'b0);
    check_eq("s3_dout", 32'(bus.dout), 32'hA5);
    check_eq("s3_valid_pulses", 32'(n_valid - v0), 32'd1);

    // 4: framing error keeps previous word
    v0 = n_valid;
    e0 = n_err;
    send_frame(8'h3C, 1'b0, 1, 1'b0);
    check_eq("s4_err", 32'(bus.frame_err), 32'd1);
    check_eq("s4_dout_kept", 32'(bus.dout), 32'hA5);
    check_eq("s4_busy", 32'(bus.busy), 32'd0);
    cycle(1'b0, 1'b1, 1'b1);
    check_eq("s4_err_pulses", 32'(n_err - e0), 32'd1);
    check_eq("s4_no_valid", 32'(n_valid - v0), 32'd0);

    // 5: back-to-back 0xFF then 0x00, no idle bits
    v0 = n_valid;
    send_frame(8'hFF, 1'b1, 1, 1'b0);
    check_eq("s5_dout_ff", 32'(bus.dout), 32'hFF);
    send_frame(8'h00, 1'b1, 1, 1'b0);
    check_eq("s5_dout_00", 32'(bus.dout), 32'h00);
    check_eq("s5_valid_pulses", 32'(n_valid - v0), 32'd2);

    // 6: reset after four data bits of 0x5A, then 0x81
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, (8'h5A >> i) & 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    check_eq("s6_busy", 32'(bus.busy), 32'd0);
    check_eq("s6_dout", 32'(bus.dout), 32'h0);
    send_frame(8'h81, 1'b1, 1, 1'b0);
    check_eq("s6_dout_81", 32'(bus.dout), 32'h81);

    // Randomized frames: random gaps, filler, idle bits, bad stops, rare resets
    for (int f = 0; f < 200; f++) begin
      int idle_bits;
      idle_bits = int'($urandom_range(0, 2));
      for (int i = 0; i < idle_bits; i++) send_bit(1'b1, 1, 1'b1);
      if ($urandom_range(0, 19) == 0) begin
        send_bit(1'b0, 1, 1'b1);
        for (int i = 0; i < int'($urandom_range(0, 9)); i++) begin
          send_bit(1'($urandom), int'($urandom_range(1, 3)), 1'b1);
        end
        cycle(1'b1, 1'($urandom), 1'($urandom));
      end else begin
        send_frame(WIDTH'($urandom), $urandom_range(0, 4) != 0,
                   int'($urandom_range(1, 3)), 1'b1);
      end
    end
    cycle(1'b0, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bit_deserializer.md
Name: bit_deserializer

Overview:
Downstream consumer of the single-bit registered stream produced by the D flip-flop stage. Frames the serial bit stream into parallel words using start/stop bits:
- start bit = 0
- WIDTH data bits, LSB first
- stop bit = 1

Each good word is presented with a one-cycle valid pulse. Framing errors are flagged. Only bits qualified by a strobe are sampled.

Parameters:
WIDTH, 8, number of data bits per frame (legal range 2..16)
CNT_W, 4, width of internal bit counter; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high; sampled on rising edge of clk
din  input  1  serial data bit (registered q of upstream flip-flop)
din_en  input  1  bit strobe; din is sampled only on cycles where din_en=1
dout  output  WIDTH  last correctly framed data word
dout_valid  output  1  one-cycle pulse: dout updated this cycle
busy  output  1  high while a frame is in progress (state != IDLE)
frame_err  output  1  one-cycle pulse: stop bit sampled as 0

Behaviour:
- Reset (rst=1 at rising edge):
  - state=IDLE, bit counter=0, shift register=0.
  - dout=0, dout_valid=0, busy=0, frame_err=0.
  - Reset has priority over all other inputs and aborts any frame in progress; no partial word is ever output.
- Cycles with din_en=0: state, counter and shift register hold. dout_valid=0, frame_err=0.
- States: IDLE, DATA, STOP.
  - IDLE: on din_en=1 and din=0 (start bit), go to DATA with counter=0. On din_en=1 and din=1, stay in IDLE (line idle).
  - DATA: on each din_en=1, shift din into the MSB of the shift register, shifting right, so the first data bit ends in bit 0. Counter increments. When the counter reaches WIDTH-1 with din_en=1, go to STOP after that bit.
  - STOP, on din_en=1:
    - din=1: dout <= shift register, and dout_valid=1 on the cycle after that edge (registered, together with dout).
    - din=0: frame_err=1 for one cycle, dout unchanged.
    - Either way, return to IDLE.
- Latency: dout/dout_valid are registered outputs. They become visible the clock after the rising edge that samples the stop bit with din_en=1.
- busy: registered, 1 in DATA and STOP, 0 in IDLE.
- dout_valid and frame_err are mutually exclusive and never high for more than one consecutive cycle, even with din_en held high.
- Back-to-back frames: a start bit may be sampled on the very next din_en after the stop bit, with no idle bits required.
- A 0 sampled in STOP is not reinterpreted as a start bit; the next frame needs a fresh start bit from IDLE.
- Data bits are not checked. All-zero and all-one words are legal.
- No X propagation: all state registers are reset. din is ignored whenever din_en=0, even if it is X.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with din toggling and din_en=1 → dout=0x00, dout_valid=0, busy=0, frame_err=0 throughout and after release.
2. Single frame, WIDTH=8, din_en=1 every cycle: stream 0, then bits of 0xA5 LSB first (1,0,1,0,0,1,0,1), then stop=1 → busy=1 for 9 cycles, dout=0xA5, dout_valid high for exactly one cycle.
3. Sparse strobe: same frame as scenario 2 with din_en=1 only every 3rd cycle and din=1 in between → dout=0xA5, single dout_valid pulse. Bits on non-strobe cycles are ignored.
4. Framing error: 0, then 0x3C LSB first, then stop=0 → frame_err pulses once, dout_valid stays 0, dout keeps its prior value 0xA5, state returns to IDLE (busy=0).
5. Back-to-back: frames 0xFF then 0x00 with no idle bits between → two dout_valid pulses 10 strobes apart, dout=0xFF then 0x00.
6. Reset mid-frame: rst=1 after 4 data bits of 0x5A → busy=0, dout=0. A following full frame 0x81 gives dout=0x81 with no residue from the aborted frame.
